// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: row drive, column sync, whole-scan
// accumulation and debounce, producing a key code with a one-cycle valid strobe.
module keypad_scan #(
  parameter int CLK_FREQ = 200_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DB_SCANS = 5
) (
  input  logic       clk,
  input  logic       sys_rstn,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // state        | meaning
  // S_IDLE       | no key accepted, waiting for a single-key scan
  // S_DB_PRESS   | candidate key seen on db_cnt consecutive scans
  // S_PRESSED    | key accepted, key_held high
  // S_DB_RELEASE | empty scans counted toward release, key_held still high
  typedef enum logic [1:0] {S_IDLE, S_DB_PRESS, S_PRESSED, S_DB_RELEASE} state_t;

  localparam int ROW_TICKS = CLK_FREQ / SCAN_HZ;
  localparam int CW = $clog2(ROW_TICKS);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROW_TICKS - 1);
  localparam logic [3:0] DB_TGT = 4'(DB_SCANS);

  logic [CW-1:0] row_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    col_s1, col_s2;
  logic [1:0]    acc_cnt, res_cnt;
  logic [3:0]    acc_code, res_code;
  logic          scan_done;
  state_t        state;
  logic [3:0]    db_cnt, cand;

  logic          sample;
  logic [3:0]    col_act;
  logic [1:0]    row_keys, col_enc, tot;
  logic [2:0]    sum;
  logic [3:0]    first_code;

  assign row_n  = ~(4'b0001 << row_idx);
  assign sample = (row_cnt == ROW_LAST);

  always_comb begin
    col_act = ~col_s2;
    if (col_act == 4'd0)
      row_keys = 2'd0;
    else if ((col_act & (col_act - 4'd1)) == 4'd0)
      row_keys = 2'd1;
    else
      row_keys = 2'd2;
    if (col_act[0])      col_enc = 2'd0;
    else if (col_act[1]) col_enc = 2'd1;
    else if (col_act[2]) col_enc = 2'd2;
    else                 col_enc = 2'd3;
    sum = {1'b0, acc_cnt} + {1'b0, row_keys};
    tot = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    // only the first pressed key of a scan is remembered; later ones only bump the count
    first_code = (acc_cnt == 2'd0 && row_keys != 2'd0) ? {row_idx, col_enc} : acc_code;
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      row_cnt   <= '0;
      row_idx   <= 2'd0;
      col_s1    <= 4'hF;
      col_s2    <= 4'hF;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      res_cnt   <= 2'd0;
      res_code  <= 4'd0;
      scan_done <= 1'b0;
    end else begin
      col_s1    <= col_n;
      col_s2    <= col_s1;
      scan_done <= 1'b0;
      if (sample) begin
        row_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          res_cnt   <= tot;
          res_code  <= first_code;
          scan_done <= 1'b1;
          acc_cnt   <= 2'd0;
          acc_code  <= 4'd0;
        end else begin
          acc_cnt  <= tot;
          acc_code <= first_code;
        end
      end else begin
        row_cnt <= row_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= S_IDLE;
      db_cnt    <= 4'd0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          S_IDLE: begin
            if (res_cnt == 2'd1) begin
              cand   <= res_code;
              db_cnt <= 4'd1;
              if (DB_SCANS == 1) begin
                state     <= S_PRESSED;
                key_code  <= res_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= S_DB_PRESS;
              end
            end
          end
          S_DB_PRESS: begin
            if (res_cnt == 2'd1 && res_code == cand) begin
              db_cnt <= db_cnt + 4'd1;
              if (db_cnt + 4'd1 == DB_TGT) begin
                state     <= S_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (res_cnt == 2'd1) begin
              cand   <= res_code;
              db_cnt <= 4'd1;
            end else begin
              state  <= S_IDLE;
              db_cnt <= 4'd0;
            end
          end
          S_PRESSED: begin
            if (res_cnt == 2'd0) begin
              if (DB_SCANS == 1) begin
                state    <= S_IDLE;
                db_cnt   <= 4'd0;
                key_held <= 1'b0;
              end else begin
                state  <= S_DB_RELEASE;
                db_cnt <= 4'd1;
              end
            end
          end
          S_DB_RELEASE: begin
            if (res_cnt == 2'd0) begin
              db_cnt <= db_cnt + 4'd1;
              if (db_cnt + 4'd1 == DB_TGT) begin
                state    <= S_IDLE;
                db_cnt   <= 4'd0;
                key_held <= 1'b0;
              end
            end else begin
              state <= S_PRESSED;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model and a queue of
// expected key_valid pulses (code and cycle) checked by a monitor.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       sys_rstn = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed = '0;

  int unsigned cyc;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  code;
    int unsigned at;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  keypad_scan #(.CLK_FREQ(1000), .SCAN_HZ(100), .DB_SCANS(3)) dut (
    .clk(clk),
    .sys_rstn(sys_rstn),
    .col_n(col_n),
    .row_n(row_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // a pressed key pulls its column low while its row is driven low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk or negedge sys_rstn)
    if (!sys_rstn) cyc <= 0;
    else           cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sys_rstn && key_valid) begin
      exp_t e;
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_code", 32'(key_code), 32'(e.code));
        check("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic next_boundary(output int unsigned b);
    @(negedge clk);
    while (cyc % 40 != 0) @(negedge clk);
    b = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned b;
    logic [3:0] er;

    repeat (3) @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    sys_rstn = 1'b1;

    // row sequencing, idle keypad
    for (int k = 5; k < 400; k += 10) begin
      wait_cyc(k);
      er = 4'b1111 ^ (4'b0001 << ((k / 10) % 4));
      check("row_n_seq", 32'(row_n), 32'(er));
    end
    wait_cyc(400);
    check("idle_held", 32'(key_held), 32'h0);

    // clean press of key 9
    next_boundary(b);
    pressed[9] = 1'b1;
    exp_q.push_back('{code: 4'd9, at: b + 121});
    wait_cyc(b + 120);
    check("t2_held_before", 32'(key_held), 32'h0);
    wait_cyc(b + 121);
    check("t2_held_rise", 32'(key_held), 32'h1);
    check("t2_valid", 32'(key_valid), 32'h1);
    wait_cyc(b + 240);
    pressed = '0;
    wait_cyc(b + 360);
    check("t2_held_last", 32'(key_held), 32'h1);
    wait_cyc(b + 361);
    check("t2_held_fall", 32'(key_held), 32'h0);

    // bouncing key 6, then stable
    next_boundary(b);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(b + 40 * i);
      pressed[6] = (i % 2 == 0);
    end
    wait_cyc(b + 160);
    pressed[6] = 1'b1;
    exp_q.push_back('{code: 4'd6, at: b + 281});
    wait_cyc(b + 280);
    check("t3_held_before", 32'(key_held), 32'h0);
    wait_cyc(b + 281);
    check("t3_held_rise", 32'(key_held), 32'h1);
    wait_cyc(b + 320);
    pressed = '0;
    wait_cyc(b + 441);
    check("t3_held_fall", 32'(key_held), 32'h0);

    // two keys from idle
    next_boundary(b);
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_cyc(b + 400);
    check("t4_held", 32'(key_held), 32'h0);
    check("t4_code_kept", 32'(key_code), 32'h6);
    pressed = '0;

    // rollover 3 -> 3+12 -> 12 -> none
    next_boundary(b);
    pressed[3] = 1'b1;
    exp_q.push_back('{code: 4'd3, at: b + 121});
    wait_cyc(b + 160);
    pressed[12] = 1'b1;
    wait_cyc(b + 240);
    pressed[3] = 1'b0;
    wait_cyc(b + 300);
    check("t5_held_rollover", 32'(key_held), 32'h1);
    wait_cyc(b + 320);
    pressed = '0;
    wait_cyc(b + 440);
    check("t5_held_last", 32'(key_held), 32'h1);
    wait_cyc(b + 441);
    check("t5_held_fall", 32'(key_held), 32'h0);
    check("t5_code", 32'(key_code), 32'h3);

    // reset during debounce of key 15
    next_boundary(b);
    pressed[15] = 1'b1;
    wait_cyc(b + 90);
    sys_rstn = 1'b0;
    #1;
    check("t6_rst_row_n", 32'(row_n), 32'hE);
    check("t6_rst_code", 32'(key_code), 32'h0);
    check("t6_rst_valid", 32'(key_valid), 32'h0);
    check("t6_rst_held", 32'(key_held), 32'h0);
    @(negedge clk);
    sys_rstn = 1'b1;
    exp_q.push_back('{code: 4'd15, at: 121});
    wait_cyc(120);
    check("t6_held_before", 32'(key_held), 32'h0);
    wait_cyc(121);
    check("t6_held_rise", 32'(key_held), 32'h1);
    wait_cyc(130);
    check("t6_code", 32'(key_code), 32'hF);
    pressed = '0;
    wait_cyc(300);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
